// File: rtl/ha_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ha_mul_pkg
// Purpose  : Shared constants, group bundle type and group-value helper for
//            the approximate 8x8 multiplier accumulation stage.
// Revision : 1.0 - initial release
// ============================================================================
package ha_mul_pkg;

  localparam int HA_GROUPS = 4;   // number of half-adder groups
  localparam int HA_B_W    = 7;   // carry-row width per group
  localparam int HA_T_W    = 9;   // sum-row width per group
  localparam int PROD_W    = 16;  // product width
  localparam int SUM_W     = 17;  // internal sum width (product + overflow)
  localparam int HA_V_W    = 10;  // unshifted group value width

  // One half-adder group: carry row b (weighted x4) and sum row t.
  typedef struct packed {
    logic [HA_B_W-1:0] b;
    logic [HA_T_W-1:0] t;
  } ha_group_t;

  // Unshifted group value: t + 4*b, fits in 10 bits (max 511 + 508).
  function automatic logic [HA_V_W-1:0] ha_group_value(input ha_group_t g);
    return {1'b0, g.t} + {1'b0, g.b, 2'b00};
  endfunction

endpackage : ha_mul_pkg
`default_nettype wire

// File: rtl/ha_group_weight.sv
`default_nettype none
// ============================================================================
// Module   : ha_group_weight
// Purpose  : Combinational weighting of one half-adder group: computes the
//            group value and shifts it left by twice the group index.
// Revision : 1.0 - initial release
// ============================================================================
module ha_group_weight
  import ha_mul_pkg::*;
(
  input  ha_group_t         i_grp,
  input  logic [1:0]        i_idx,
  output logic [PROD_W-1:0] o_v
);

  logic [HA_V_W-1:0] w_raw;
  logic [PROD_W-1:0] w_ext;
  logic [2:0]        w_shamt;

  // Group value zero-extended, then placed at bit position 2*index.
  // The largest result (1019 << 6) still fits in 16 bits.
  always_comb begin
    w_raw   = ha_group_value(i_grp);
    w_ext   = {{(PROD_W-HA_V_W){1'b0}}, w_raw};
    w_shamt = {i_idx, 1'b0};
    o_v     = w_ext << w_shamt;
  end

endmodule : ha_group_weight
`default_nettype wire

// File: rtl/ha_array_accum.sv
`default_nettype none
// ============================================================================
// Module   : ha_array_accum
// Purpose  : Two-stage valid/ready pipeline reducing the four half-adder
//            groups of the approximate 8x8 multiplier to a 16-bit product
//            plus an overflow flag (bit 16 of the internal sum).
//            Stage A: s01 = V0 + V1, s23 = V2 + V3.
//            Stage B: sum = s01 + s23 (+ COMP_BIAS when enabled).
// Options  : define ERR_COMP_EN to add COMP_BIAS to every non-zero sum.
// Revision : 1.0 - initial release
// ============================================================================
module ha_array_accum
  import ha_mul_pkg::*;
#(
  parameter int PROD_W    = 16,
  parameter int COMP_BIAS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        ha_array_0_b,
  input  logic [8:0]        ha_array_0_t,
  input  logic [6:0]        ha_array_1_b,
  input  logic [8:0]        ha_array_1_t,
  input  logic [6:0]        ha_array_2_b,
  input  logic [8:0]        ha_array_2_t,
  input  logic [6:0]        ha_array_3_b,
  input  logic [8:0]        ha_array_3_t,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] prod,
  output logic              prod_ovf
);

  localparam int c_S01_W = 13;   // V0 + V1 max is 1019*5
  localparam int c_S23_W = 17;   // V2 + V3 max is 1019*80

  // --------------------------------------------------------------------------
  // Group weighting
  // --------------------------------------------------------------------------
  ha_group_t   w_grp [HA_GROUPS];
  logic [15:0] w_v   [HA_GROUPS];

  assign w_grp[0] = '{b: ha_array_0_b, t: ha_array_0_t};
  assign w_grp[1] = '{b: ha_array_1_b, t: ha_array_1_t};
  assign w_grp[2] = '{b: ha_array_2_b, t: ha_array_2_t};
  assign w_grp[3] = '{b: ha_array_3_b, t: ha_array_3_t};

  generate
    for (genvar k = 0; k < HA_GROUPS; k++) begin : g_grp
      ha_group_weight u_weight (
        .i_grp (w_grp[k]),
        .i_idx (2'(k)),
        .o_v   (w_v[k])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic r_a_valid;
  logic r_out_valid;
  logic w_b_load;
  logic w_a_load;

  // Stage B can take new data when empty or when its product is leaving.
  assign w_b_load = !r_out_valid || out_ready;
  // Stage A can take new data when empty or when its data moves to stage B.
  assign in_ready = !r_a_valid || w_b_load;
  assign w_a_load = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Stage A: pairwise sums
  // --------------------------------------------------------------------------
  logic [c_S01_W-1:0] w_s01;
  logic [c_S23_W-1:0] w_s23;
  logic [c_S01_W-1:0] r_s01;
  logic [c_S23_W-1:0] r_s23;

  // Low pair fits in 13 bits, high pair needs the full 17 bits.
  always_comb begin
    w_s01 = c_S01_W'(w_v[0]) + c_S01_W'(w_v[1]);
    w_s23 = {1'b0, w_v[2]} + {1'b0, w_v[3]};
  end

  // Stage A register: load on accepted input, empty when drained forward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_s01     <= '0;
      r_s23     <= '0;
    end else if (w_a_load) begin
      r_a_valid <= 1'b1;
      r_s01     <= w_s01;
      r_s23     <= w_s23;
    end else if (w_b_load) begin
      r_a_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Stage B: final sum
  // --------------------------------------------------------------------------
  logic [SUM_W-1:0] w_sum_raw;
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] r_sum;

`ifdef ERR_COMP_EN
  localparam logic [SUM_W-1:0] c_BIAS = SUM_W'(COMP_BIAS);
  logic w_nonzero;

  // Bias recentres the one-sided approximation error; a zero product
  // stays zero so the bias is skipped when both partial sums are zero.
  always_comb begin
    w_sum_raw = {{(SUM_W-c_S01_W){1'b0}}, r_s01} + r_s23;
    w_nonzero = (|r_s01) || (|r_s23);
    w_sum     = w_sum_raw + (w_nonzero ? c_BIAS : {SUM_W{1'b0}});
  end
`else
  // Exact reduction of the two partial sums.
  always_comb begin
    w_sum_raw = {{(SUM_W-c_S01_W){1'b0}}, r_s01} + r_s23;
    w_sum     = w_sum_raw;
  end
`endif

  // Stage B register: holds product and valid while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
    end else if (w_b_load) begin
      r_out_valid <= r_a_valid;
      if (r_a_valid) begin
        r_sum <= w_sum;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign prod      = r_sum[PROD_W-1:0];
  assign prod_ovf  = r_sum[SUM_W-1];

endmodule : ha_array_accum
`default_nettype wire

// File: tb/tb_ha_array_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_ha_array_accum
// Purpose  : Self-checking bench for ha_array_accum: directed cases for
//            reset, latency, group weighting, overflow and backpressure,
//            then a randomized stream against a bit-weight reference model.
// Options  : honours ERR_COMP_EN (bias of 64 on non-zero products).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ha_array_accum;

`ifdef ERR_COMP_EN
  localparam int unsigned BIAS  = 64;
  localparam int unsigned E_T0  = 32'd65;
  localparam int unsigned E_B3  = 32'h4040;
  localparam int unsigned E_G1  = 32'd4140;
  localparam int unsigned E_ALL = 32'h15297;
`else
  localparam int unsigned BIAS  = 0;
  localparam int unsigned E_T0  = 32'd1;
  localparam int unsigned E_B3  = 32'h4000;
  localparam int unsigned E_G1  = 32'd4076;
  localparam int unsigned E_ALL = 32'h15257;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [6:0]  b [4];
  logic [8:0]  t [4];
  logic        in_ready;
  logic        out_valid;
  logic [15:0] prod;
  logic        prod_ovf;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned exp_q [$];

  logic [35:0] tv, tv_a, tv_b, tv_c;
  logic [27:0] bv, bv_a, bv_b, bv_c;
  int unsigned e_a, e_b, e_c;
  int          sent, cycles;

  always #5 clk = ~clk;

  ha_array_accum dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_b (b[0]),
    .ha_array_0_t (t[0]),
    .ha_array_1_b (b[1]),
    .ha_array_1_t (t[1]),
    .ha_array_2_b (b[2]),
    .ha_array_2_t (t[2]),
    .ha_array_3_b (b[3]),
    .ha_array_3_t (t[3]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .prod         (prod),
    .prod_ovf     (prod_ovf)
  );

  // Reference: every set bit contributes its own power of two.
  // t of group k bit i -> 2^(2k+i); b of group k bit i -> 2^(2k+i+2).
  function automatic int unsigned model_sum(input logic [35:0] tvec, input logic [27:0] bvec);
    int unsigned s = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 9; i++) if (tvec[9*k+i]) s += 32'd1 << (2*k + i);
      for (int i = 0; i < 7; i++) if (bvec[7*k+i]) s += 32'd1 << (2*k + i + 2);
    end
    if (s != 0) s += BIAS;
    return s;
  endfunction

  function automatic int unsigned observed();
    return {15'd0, prod_ovf, prod};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [35:0] tvec, input logic [27:0] bvec);
    in_valid = v;
    for (int k = 0; k < 4; k++) begin
      t[k] = tvec[9*k +: 9];
      b[k] = bvec[7*k +: 7];
    end
  endtask

  // One isolated bundle with out_ready=1: product visible exactly two edges later.
  task automatic run_single(input string tag, input logic [35:0] tvec, input logic [27:0] bvec,
                            input int unsigned exp);
    @(negedge clk); out_ready = 1'b1; drive(1'b1, tvec, bvec);
    #1 check({tag, " in_ready"}, in_ready, 1);
    @(negedge clk); drive(1'b0, '0, '0);
    #1 check({tag, " not early"}, out_valid, 0);
    @(negedge clk);
    #1 check({tag, " out_valid"}, out_valid, 1);
    check({tag, " prod"}, observed(), exp);
    @(negedge clk);
    #1 check({tag, " drained"}, out_valid, 0);
  endtask

  initial begin
    drive(1'b0, '0, '0);
    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    #1 check("reset out_valid", out_valid, 0);
    check("reset prod", observed(), 0);
    @(negedge clk); rst = 1'b0;
    #1 check("post-reset in_ready", in_ready, 1);

    // ---------------- directed single bundles ----------------
    run_single("t0_lsb", 36'h1, 28'h0, E_T0);
    bv = 28'h40 << 21;
    run_single("b3_msb", 36'h0, bv, E_B3);
    tv = 36'h1FF << 9; bv = 28'h7F << 7;
    run_single("grp1_full", tv, bv, E_G1);
    run_single("all_ones_ovf", '1, '1, E_ALL);
    run_single("all_zero", '0, '0, 0);

    // ---------------- backpressure ----------------
    tv_a = 36'({$urandom(), $urandom()}); bv_a = 28'($urandom());
    tv_b = 36'({$urandom(), $urandom()}); bv_b = 28'($urandom());
    tv_c = 36'({$urandom(), $urandom()}); bv_c = 28'($urandom());
    e_a = model_sum(tv_a, bv_a); e_b = model_sum(tv_b, bv_b); e_c = model_sum(tv_c, bv_c);
    @(negedge clk); out_ready = 1'b0; drive(1'b1, tv_a, bv_a);
    #1 check("bp accept a", in_ready, 1);
    @(negedge clk); drive(1'b1, tv_b, bv_b);
    #1 check("bp accept b", in_ready, 1);
    @(negedge clk); drive(1'b1, tv_c, bv_c);
    #1 check("bp full", in_ready, 0);
    check("bp out_valid", out_valid, 1);
    check("bp first prod", observed(), e_a);
    @(negedge clk);
    #1 check("bp still full", in_ready, 0);
    check("bp stable prod", observed(), e_a);
    out_ready = 1'b1;
    #1 check("bp release", in_ready, 1);
    @(negedge clk); drive(1'b0, '0, '0);
    #1 check("bp second valid", out_valid, 1);
    check("bp second prod", observed(), e_b);
    @(negedge clk);
    #1 check("bp third prod", observed(), e_c);
    @(negedge clk);
    #1 check("bp empty", out_valid, 0);

    // ---------------- reset mid-stream ----------------
    @(negedge clk); out_ready = 1'b0; drive(1'b1, tv_a, bv_a);
    @(negedge clk); drive(1'b1, tv_b, bv_b);
    @(negedge clk); drive(1'b0, '0, '0);
    #1 check("rst pre full", out_valid, 1);
    #1 rst = 1'b1;
    #1 check("rst async out_valid", out_valid, 0);
    check("rst async prod", observed(), 0);
    @(negedge clk); rst = 1'b0;
    #1 check("rst release in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check("rst nothing emitted", out_valid, 0);
    end

    // ---------------- randomized stream ----------------
    exp_q.delete();
    sent = 0; cycles = 0;
    while ((sent < 256 || exp_q.size() != 0) && cycles < 5000) begin
      @(negedge clk);
      cycles++;
      out_ready = ($urandom_range(0, 2) != 0);
      if (sent < 256 && $urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 7) == 0) begin
          tv = '0; bv = '0;
        end else begin
          tv = 36'({$urandom(), $urandom()}); bv = 28'($urandom());
        end
        drive(1'b1, tv, bv);
      end else begin
        drive(1'b0, '0, '0);
      end
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("stream duplicate", 1, 0);
        else check("stream prod", observed(), exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_sum(tv, bv));
        sent++;
      end
    end
    check("stream within budget", (cycles < 5000), 1);
    check("stream all sent", sent, 256);
    check("stream nothing left", exp_q.size(), 0);
    drive(1'b0, '0, '0);
    @(negedge clk);
    #1 check("stream idle", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ha_array_accum
`default_nettype wire
